line_buffer_ntap: RTL

Parametrised multi-line buffer for the windowed filters (median, Sobel, bicubic pre-stage): stores the last NUM_TAPS video lines in inferred dual-port RAMs and presents, for every accepted pixel, the co-located pixels of the NUM_TAPS previous lines, aligned with the delayed current pixel. It adds generic data width, tap count and line length, frame-aware top-border handling (zero or replicate), an aligned output valid and line-overflow detection. It sits between the pixel source (href/clken timing) and the window-register stage of each filter.

---
 rtl/line_buffer_ntap.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/line_buffer_ntap.sv
// line_buffer_ntap: multi-line video buffer. Keeps the last NUM_TAPS lines in
// inferred dual-port RAMs and, for every accepted pixel, presents the
// co-located pixels of the previous lines aligned with the delayed pixel.
// Lines not yet seen in the current frame are masked (zero or replicate).
module line_buffer_ntap #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_TAPS = 2,
   parameter int unsigned ADDR_W   = 10
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic                       per_frame_vsync,
   input  logic                       per_frame_href,
   input  logic                       clken,
   input  logic                       border_mode,
   input  logic [DATA_W-1:0]          shiftin,
   output logic [DATA_W-1:0]          cur_out,
   output logic [NUM_TAPS*DATA_W-1:0] taps,
   output logic                       out_valid,
   output logic [ADDR_W-1:0]          line_cnt,
   output logic                       line_overflow
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned LS_W  = $clog2(NUM_TAPS + 1);

   // column / frame state
   logic [ADDR_W-1:0] r_col;
   logic              r_col_full;
   logic              r_href_d;
   logic [ADDR_W-1:0] r_line_cnt;
   logic [LS_W-1:0]   r_lines_seen;
   logic              r_overflow;

   // stage 1
   logic              r_s1_vld;
   logic [DATA_W-1:0] r_s1_pix;
   logic [ADDR_W-1:0] r_s1_col;

   // stage 2
   logic                             r_out_valid;
   logic [DATA_W-1:0]                r_cur;
   logic [NUM_TAPS-1:0][DATA_W-1:0]  r_taps;

   logic                             w_accept;
   logic                             w_take;
   logic                             w_line_end;
   logic [31:0]                      w_lines;
   logic [DATA_W-1:0]                w_rep;
   logic [NUM_TAPS-1:0][DATA_W-1:0]  w_rd;
   logic [NUM_TAPS-1:0][DATA_W-1:0]  w_taps;

   // vsync wins over href/clken; a full line drops further pixels
   assign w_accept   = per_frame_href & clken & ~per_frame_vsync;
   assign w_take     = w_accept & ~r_col_full;
   // a line counts only if it delivered at least one pixel
   assign w_line_end = r_href_d & ~per_frame_href & ~per_frame_vsync &
                       ((r_col != '0) | r_col_full);
   assign w_lines    = 32'(r_lines_seen);

   // column counter: cleared outside the active line, saturates into r_col_full
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_col      <= '0;
         r_col_full <= 1'b0;
      end else if (per_frame_vsync || !per_frame_href) begin
         r_col      <= '0;
         r_col_full <= 1'b0;
      end else if (w_take) begin
         if (r_col == '1) r_col_full <= 1'b1;
         else             r_col      <= r_col + 1'b1;
      end
   end

   // frame bookkeeping: line counters, href edge detect, sticky overflow
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_href_d     <= 1'b0;
         r_line_cnt   <= '0;
         r_lines_seen <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_href_d <= per_frame_href;
         if (per_frame_vsync) begin
            r_line_cnt   <= '0;
            r_lines_seen <= '0;
            r_overflow   <= 1'b0;
         end else begin
            if (w_accept && r_col_full) r_overflow <= 1'b1;
            if (w_line_end) begin
               if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + 1'b1;
               if (r_lines_seen != LS_W'(NUM_TAPS)) r_lines_seen <= r_lines_seen + 1'b1;
            end
         end
      end
   end

   // stage 1: capture the accepted pixel and its column; hold during stalls
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s1_pix <= '0;
         r_s1_col <= '0;
      end else begin
         r_s1_vld <= w_take;
         if (w_take) begin
            r_s1_pix <= shiftin;
            r_s1_col <= r_col;
         end
      end
   end

   // one RAM per tap; RAM k is refilled from RAM k-1's read data so the
   // lines shift down by one each time a column is rewritten
   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_line
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [DATA_W-1:0] r_rd;
      logic [DATA_W-1:0] w_wdata;

      if (k == 0) begin : g_first
         assign w_wdata = r_s1_pix;
      end else begin : g_cascade
         assign w_wdata = w_rd[k-1];
      end

      // write port: stage-2 write of the previous column
      always_ff @(posedge clock) begin
         if (r_s1_vld) r_mem[r_s1_col] <= w_wdata;
      end

      // read port: synchronous read of the column being accepted
      always_ff @(posedge clock) begin
         if (w_take) r_rd <= r_mem[r_col];
      end

      assign w_rd[k] = r_rd;
   end

   // border masking: taps beyond the lines seen this frame read 0 or the
   // nearest valid line (the current pixel when no line has been seen)
   always_comb begin
      w_rep  = r_s1_pix;
      w_taps = '0;
      for (int unsigned j = 0; j < NUM_TAPS; j++) begin
         if (j + 1 == w_lines) w_rep = w_rd[j];
      end
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
         if (k < w_lines)      w_taps[k] = w_rd[k];
         else if (border_mode) w_taps[k] = w_rep;
         else                  w_taps[k] = '0;
      end
   end

   // stage 2: register aligned outputs
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_cur       <= '0;
         r_taps      <= '0;
      end else begin
         r_out_valid <= r_s1_vld;
         if (r_s1_vld) begin
            r_cur  <= r_s1_pix;
            r_taps <= w_taps;
         end
      end
   end

   assign cur_out       = r_cur;
   assign taps          = r_taps;
   assign out_valid     = r_out_valid;
   assign line_cnt      = r_line_cnt;
   assign line_overflow = r_overflow;

endmodule
